// File: rtl/tile_engine.sv
// tile_engine: frame-paced piano-tiles playfield (scroll, hit judgement, score, win/loss).
// Define TILE_ENGINE_COMBO_EN to enable the combo / best_combo streak counters.
module tile_engine #(
  parameter int LANES           = 4,
  parameter int ROWS            = 5,
  parameter int SONG_LEN        = 31,
  parameter int FRAME_CYCLES    = 1666666,
  parameter int STARTING_OFFSET = 90,
  parameter int KEY_HEIGHT      = 30,
  parameter int HITBOX_TOP      = 100,
  parameter int HITBOX_BOTTOM   = 110
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LANES-1:0]          key_pressed,
  input  logic [LANES*SONG_LEN-1:0] song_in,
  output logic [8:0]                yoffset,
  output logic [LANES*ROWS-1:0]     keys,
  output logic [1:0]                num_hit,
  output logic [9:0]                score,
  output logic                      busy,
  output logic                      won,
  output logic                      lost,
  output logic                      frame_done,
  output logic [7:0]                combo,
  output logic [7:0]                best_combo
);
  localparam int CW = $clog2(FRAME_CYCLES);
  localparam int PW = $clog2(SONG_LEN + 1);
  localparam logic [9:0]    SO       = 10'(STARTING_OFFSET);
  localparam logic [9:0]    KH       = 10'(KEY_HEIGHT);
  localparam logic [9:0]    HT       = 10'(HITBOX_TOP);
  localparam logic [9:0]    HB       = 10'(HITBOX_BOTTOM);
  localparam logic [9:0]    WRAP     = SO + KH;
  localparam logic [PW-1:0] PTR_END  = PW'(SONG_LEN);
  localparam logic [PW-1:0] PTR_INIT = PW'(ROWS);
  localparam logic [CW-1:0] CNT_INIT = CW'(FRAME_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_UPDATE, S_WON, S_LOST
  } state_t;

  state_t                    state_q;
  logic [LANES*SONG_LEN-1:0] song_q;
  logic [LANES*ROWS-1:0]     keys_q;
  logic [PW-1:0]             ptr_q;
  logic [8:0]                yoff_q;
  logic [1:0]                num_hit_q;
  logic [9:0]                score_q;
  logic                      won_q, lost_q, frame_done_q;
  logic [LANES-1:0]          hit_q;
  logic [CW-1:0]             cnt_q;

  logic [9:0]       y;
  logic [LANES-1:0] row0, row1, top_row;
  logic             miss, judge0, judge1, good_hit, bad_hit, all_clear;

  // Judgement terms; miss and the two windows are mutually exclusive by construction.
  always_comb begin
    y       = {1'b0, yoff_q};
    row0    = keys_q[0 +: LANES];
    row1    = keys_q[LANES +: LANES];
    top_row = '0;
    if (ptr_q < PTR_END) top_row = song_q[LANES*int'(ptr_q) +: LANES];
    miss      = (y > HB) && (num_hit_q == 2'd0) && (row0 != '0);
    judge0    = (y + KH > HT) && (y < HB) && (num_hit_q == 2'd0) && (hit_q != '0);
    judge1    = (y > HT) && (y - KH < HB) && (num_hit_q == 2'd1) && (hit_q != '0);
    good_hit  = !miss && ((judge0 && (hit_q == row0)) || (judge1 && (hit_q == row1)));
    bad_hit   = miss || (judge0 && (hit_q != row0)) || (judge1 && (hit_q != row1));
    all_clear = (keys_q == '0) && (ptr_q == PTR_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      song_q       <= '0;
      keys_q       <= '0;
      ptr_q        <= '0;
      yoff_q       <= 9'(STARTING_OFFSET);
      num_hit_q    <= '0;
      score_q      <= '0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      frame_done_q <= 1'b0;
      hit_q        <= '0;
      cnt_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if ((hit_q == '0) && (key_pressed != '0)) hit_q <= key_pressed;
      case (state_q)
        S_IDLE, S_WON, S_LOST: if (start) state_q <= S_LOAD;
        S_LOAD: begin
          song_q    <= song_in;
          keys_q    <= song_in[LANES*ROWS-1:0];
          ptr_q     <= PTR_INIT;
          yoff_q    <= 9'(STARTING_OFFSET);
          score_q   <= '0;
          num_hit_q <= '0;
          won_q     <= 1'b0;
          lost_q    <= 1'b0;
          hit_q     <= '0;
          cnt_q     <= CNT_INIT;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_CHECK;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_CHECK: begin
          if (bad_hit) begin
            lost_q  <= 1'b1;
            state_q <= S_LOST;
          end else begin
            if (good_hit) begin
              num_hit_q <= num_hit_q + 2'd1;
              if (score_q != '1) score_q <= score_q + 10'd1;
            end
            if (all_clear) begin
              won_q   <= 1'b1;
              state_q <= S_WON;
            end else begin
              state_q <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          hit_q        <= '0;
          frame_done_q <= 1'b1;
          cnt_q        <= CNT_INIT;
          state_q      <= S_WAIT;
          if (y == WRAP) begin
            yoff_q <= 9'(STARTING_OFFSET);
            keys_q <= {top_row, keys_q[LANES*ROWS-1:LANES]};
            if (ptr_q != PTR_END) ptr_q <= ptr_q + 1'b1;
            if (num_hit_q != 2'd0) num_hit_q <= num_hit_q - 2'd1;
          end else begin
            yoff_q <= yoff_q + 9'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef TILE_ENGINE_COMBO_EN
  logic [7:0] combo_q, best_q, combo_inc;
  assign combo_inc = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      combo_q <= '0;
      best_q  <= '0;
    end else if (state_q == S_LOAD) begin
      combo_q <= '0;
      best_q  <= '0;
    end else if (state_q == S_CHECK) begin
      if (bad_hit) begin
        combo_q <= '0;
      end else if (good_hit) begin
        combo_q <= combo_inc;
        if (combo_inc > best_q) best_q <= combo_inc;
      end
    end
  end

  assign combo      = combo_q;
  assign best_combo = best_q;
`else
  assign combo      = '0;
  assign best_combo = '0;
`endif

  assign yoffset    = yoff_q;
  assign keys       = keys_q;
  assign num_hit    = num_hit_q;
  assign score      = score_q;
  assign busy       = !((state_q == S_IDLE) || (state_q == S_WON) || (state_q == S_LOST));
  assign won        = won_q;
  assign lost       = lost_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tile_engine.sv
// Directed self-checking bench for tile_engine with a 2-cycle frame and a 0001,0010,0100,1000,... song.
// Combo expectations follow TILE_ENGINE_COMBO_EN when it is defined for the build.
module tb_tile_engine;
  localparam int LANES    = 4;
  localparam int ROWS     = 5;
  localparam int SONG_LEN = 31;
  localparam logic [19:0] INIT_KEYS  = 20'h18421;
  localparam logic [19:0] WRAP1_KEYS = 20'h21842;
`ifdef TILE_ENGINE_COMBO_EN
  localparam bit COMBO_ON = 1'b1;
`else
  localparam bit COMBO_ON = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic [LANES-1:0]          key_pressed;
  logic [LANES*SONG_LEN-1:0] song_in;
  logic [8:0]                yoffset;
  logic [LANES*ROWS-1:0]     keys;
  logic [1:0]                num_hit;
  logic [9:0]                score;
  logic                      busy, won, lost, frame_done;
  logic [7:0]                combo, best_combo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_engine #(
    .LANES(LANES), .ROWS(ROWS), .SONG_LEN(SONG_LEN), .FRAME_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .key_pressed(key_pressed), .song_in(song_in),
    .yoffset(yoffset), .keys(keys), .num_hit(num_hit), .score(score), .busy(busy),
    .won(won), .lost(lost), .frame_done(frame_done), .combo(combo), .best_combo(best_combo)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; key_pressed = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the first WAIT cycle of the next frame whose yoffset equals v.
  task automatic wait_yoff(input logic [8:0] v, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (frame_done && (yoffset == v)) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic press(input logic [LANES-1:0] k);
    key_pressed = k;
    @(negedge clk);
    key_pressed = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (yoffset !== 9'd90) begin $display("FAIL reset_yoffset: got %0d want 90", yoffset); errors++; end
    checks++; if (keys !== '0) begin $display("FAIL reset_keys: got %h want 0", keys); errors++; end
    checks++; if ({busy, won, lost, frame_done, num_hit, score} !== '0) begin
      $display("FAIL reset_flags: busy=%b won=%b lost=%b fd=%b num_hit=%0d score=%0d want all 0", busy, won, lost, frame_done, num_hit, score); errors++; end
    checks++; if ({combo, best_combo} !== '0) begin $display("FAIL reset_combo: got %0d/%0d want 0/0", combo, best_combo); errors++; end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || yoffset !== 9'd90) begin $display("FAIL idle_hold: busy=%b yoffset=%0d want 0/90", busy, yoffset); errors++; end
  endtask

  task automatic test_hit();
    bit to;
    do_reset(); do_start();
    @(negedge clk);
    checks++; if (keys !== INIT_KEYS || busy !== 1'b1 || yoffset !== 9'd90) begin
      $display("FAIL load_state: keys=%h busy=%b yoffset=%0d want %h/1/90", keys, busy, yoffset, INIT_KEYS); errors++; end
    wait_yoff(9'd95, to);
    checks++; if (to) begin $display("FAIL hit_wait95: timeout, want yoffset 95"); errors++; end
    press(4'b0001);
    wait_yoff(9'd96, to);
    checks++; if (to || score !== 10'd1 || num_hit !== 2'd1 || lost !== 1'b0) begin
      $display("FAIL hit_row0: to=%b score=%0d num_hit=%0d lost=%b want 0/1/1/0", to, score, num_hit, lost); errors++; end
    wait_yoff(9'd90, to);
    checks++; if (to || num_hit !== 2'd0 || score !== 10'd1 || keys !== WRAP1_KEYS) begin
      $display("FAIL hit_wrap: to=%b num_hit=%0d score=%0d keys=%h want 0/0/1/%h", to, num_hit, score, keys, WRAP1_KEYS); errors++; end
  endtask

  task automatic test_row1();
    bit to;
    do_reset(); do_start();
    wait_yoff(9'd95, to);
    press(4'b0001);
    wait_yoff(9'd105, to);
    checks++; if (to || num_hit !== 2'd1) begin $display("FAIL row1_pre: to=%b num_hit=%0d want 0/1", to, num_hit); errors++; end
    press(4'b0010);
    wait_yoff(9'd106, to);
    checks++; if (to || score !== 10'd2 || num_hit !== 2'd2) begin
      $display("FAIL row1_hit: to=%b score=%0d num_hit=%0d want 0/2/2", to, score, num_hit); errors++; end
    checks++; if (combo !== (COMBO_ON ? 8'd2 : 8'd0) || best_combo !== (COMBO_ON ? 8'd2 : 8'd0)) begin
      $display("FAIL row1_combo: got %0d/%0d want %0d", combo, best_combo, COMBO_ON ? 2 : 0); errors++; end
    wait_yoff(9'd90, to);
    checks++; if (to || num_hit !== 2'd1) begin $display("FAIL row1_wrap: to=%b num_hit=%0d want 0/1", to, num_hit); errors++; end
    wait_yoff(9'd112, to);
    checks++; if (to || lost !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL row1_nomiss: to=%b lost=%b busy=%b want 0/0/1", to, lost, busy); errors++; end
  endtask

  task automatic test_wrong_key();
    bit to;
    do_reset(); do_start();
    wait_yoff(9'd95, to);
    press(4'b0010);
    @(negedge clk);
    checks++; if (to || lost !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL wrong_check_cycle: to=%b lost=%b busy=%b want 0/0/1", to, lost, busy); errors++; end
    @(negedge clk);
    checks++; if (lost !== 1'b1 || busy !== 1'b0 || score !== 10'd0 || won !== 1'b0) begin
      $display("FAIL wrong_lost: lost=%b busy=%b score=%0d won=%b want 1/0/0/0", lost, busy, score, won); errors++; end
    repeat (6) @(negedge clk);
    checks++; if (yoffset !== 9'd95 || lost !== 1'b1 || combo !== 8'd0) begin
      $display("FAIL wrong_frozen: yoffset=%0d lost=%b combo=%0d want 95/1/0", yoffset, lost, combo); errors++; end
  endtask

  task automatic test_miss();
    int n;
    do_reset(); do_start();
    n = 0;
    while (n < 300 && lost !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 88) begin $display("FAIL miss_latency: got %0d cycles after LOAD want 88", n); errors++; end
    checks++; if (lost !== 1'b1 || yoffset !== 9'd111 || busy !== 1'b0 || score !== 10'd0) begin
      $display("FAIL miss_state: lost=%b yoffset=%0d busy=%b score=%0d want 1/111/0/0", lost, yoffset, busy, score); errors++; end
  endtask

  task automatic test_win();
    bit to;
    int n;
    logic [LANES-1:0] pat;
    do_reset(); do_start();
    for (int r = 0; r < SONG_LEN; r++) begin
      wait_yoff(9'd95, to);
      checks++; if (to) begin $display("FAIL win_wait_row%0d: timeout, want yoffset 95", r); errors++; end
      pat = 4'(1 << (r % 4));
      press(pat);
    end
    n = 0;
    while (n < 400 && won !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++; if (won !== 1'b1 || lost !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL win_flags: won=%b lost=%b busy=%b want 1/0/0", won, lost, busy); errors++; end
    checks++; if (score !== 10'(SONG_LEN) || keys !== '0) begin
      $display("FAIL win_score: score=%0d keys=%h want %0d/0", score, keys, SONG_LEN); errors++; end
    checks++; if (combo !== (COMBO_ON ? 8'(SONG_LEN) : 8'd0) || best_combo !== (COMBO_ON ? 8'(SONG_LEN) : 8'd0)) begin
      $display("FAIL win_combo: got %0d/%0d want %0d", combo, best_combo, COMBO_ON ? SONG_LEN : 0); errors++; end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset(); do_start();
    wait_yoff(9'd95, to);
    press(4'b0001);
    wait_yoff(9'd97, to);
    checks++; if (to || score !== 10'd1) begin $display("FAIL rmid_pre: to=%b score=%0d want 0/1", to, score); errors++; end
    reset = 1'b1;
    #1;
    checks++; if (yoffset !== 9'd90 || keys !== '0 || score !== '0 || num_hit !== '0) begin
      $display("FAIL rmid_async: yoffset=%0d keys=%h score=%0d num_hit=%0d want 90/0/0/0", yoffset, keys, score, num_hit); errors++; end
    checks++; if ({busy, won, lost, frame_done, combo, best_combo} !== '0) begin
      $display("FAIL rmid_flags: busy=%b won=%b lost=%b fd=%b combo=%0d best=%0d want all 0", busy, won, lost, frame_done, combo, best_combo); errors++; end
    @(negedge clk); reset = 1'b0;
    do_start();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || score !== 10'd0 || keys !== INIT_KEYS || yoffset !== 9'd90) begin
      $display("FAIL rmid_restart: busy=%b score=%0d keys=%h yoffset=%0d want 1/0/%h/90", busy, score, keys, yoffset, INIT_KEYS); errors++; end
  endtask

  task automatic test_double_press();
    bit to;
    do_reset(); do_start();
    wait_yoff(9'd95, to);
    key_pressed = 4'b0001;
    @(negedge clk);
    key_pressed = 4'b0100;
    start = 1'b1;
    @(negedge clk);
    key_pressed = '0;
    start = 1'b0;
    wait_yoff(9'd96, to);
    checks++; if (to || score !== 10'd1 || num_hit !== 2'd1 || lost !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL double_press: to=%b score=%0d num_hit=%0d lost=%b busy=%b want 0/1/1/0/1", to, score, num_hit, lost, busy); errors++; end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_pressed = '0;
    for (int r = 0; r < SONG_LEN; r++) song_in[r*LANES +: LANES] = 4'(1 << (r % 4));
    test_reset();
    test_hit();
    test_row1();
    test_wrong_key();
    test_miss();
    test_win();
    test_reset_mid();
    test_double_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
